// File: rtl/tff_seq_ctrl_pkg.sv
// Shared encodings and defaults for the T flip-flop sequencer.
package tff_seq_ctrl_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_LEN_W = 8;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'd0,
    OP_LOAD  = 2'd1,
    OP_UP    = 2'd2,
    OP_DOWN  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Count commands take their step count from cmd_len; the others take one step.
  function automatic logic is_count(input op_t op);
    return (op == OP_UP) || (op == OP_DOWN);
  endfunction

endpackage

// File: rtl/tff_seq_ctrl_if.sv
// Command handshake bundle: the issuer is master, the sequencer is slave.
interface tff_seq_ctrl_if
  import tff_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_arg;
  logic [LEN_W-1:0] cmd_len;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, cmd_len,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, cmd_len,
    output cmd_ready
  );
endinterface

// File: rtl/tff_seq_ctrl_cell.sv
// Single T flip-flop: toggles on a rising edge when t is high.
module tff_cell (
  input  logic ck,
  input  logic rs,
  input  logic t,
  output logic q
);

  // Toggle storage with asynchronous clear.
  always_ff @(posedge ck or posedge rs) begin
    if (rs) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/tff_seq_ctrl.sv
// Command sequencer driving a bank of T flip-flops as counter/register.
// The bank is only ever written through its toggle inputs; every operation
// is expressed as the set of bits that must flip this cycle.
module tff_seq_ctrl
  import tff_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             ck,
  input  logic             rs,
  tff_seq_ctrl_if.slave    cmd,
  input  logic             halt,
  output logic [WIDTH-1:0] t_vec,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_t           state_q, state_d;
  op_t              op_q;
  op_t              cmd_op_c;
  logic [WIDTH-1:0] arg_q;
  logic [LEN_W-1:0] rem_q;
  logic             wrap_q, wrap_d;
  logic             step;

  // Up-count toggles: bit i flips when every lower bit is one.
  function automatic logic [WIDTH-1:0] up_mask(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] m;
    logic             carry;
    carry = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      m[i]  = carry;
      carry = carry & v[i];
    end
    return m;
  endfunction

  // Down-count toggles: bit i flips when every lower bit is zero.
  function automatic logic [WIDTH-1:0] down_mask(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] m;
    logic             borrow;
    borrow = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      m[i]   = borrow;
      borrow = borrow & ~v[i];
    end
    return m;
  endfunction

  assign cmd_op_c = op_t'(cmd.cmd_op);
  assign step     = (state_q == S_RUN) && !halt;

  // Toggle vector for the current step; zero whenever the bank must hold.
  always_comb begin
    t_vec = '0;
    if (step) begin
      case (op_q)
        OP_CLEAR: t_vec = q;
        OP_LOAD:  t_vec = q ^ arg_q;
        OP_UP:    t_vec = up_mask(q);
        OP_DOWN:  t_vec = down_mask(q);
        default:  t_vec = '0;
      endcase
    end
  end

  // A wrap is a count step leaving the extreme value of the bank.
  always_comb begin
    wrap_d = 1'b0;
    if (step) begin
      wrap_d = ((op_q == OP_UP)   && (&q)) ||
               ((op_q == OP_DOWN) && !(|q));
    end
  end

  // Next-state logic; a zero-length count skips RUN entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          if (is_count(cmd_op_c) && (cmd.cmd_len == '0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (step && (rem_q == LEN_W'(1))) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM register plus command capture and step bookkeeping.
  always_ff @(posedge ck or posedge rs) begin
    if (rs) begin
      state_q <= S_IDLE;
      op_q    <= OP_CLEAR;
      arg_q   <= '0;
      rem_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wrap_q  <= wrap_d;
      if ((state_q == S_IDLE) && cmd.cmd_valid) begin
        op_q  <= cmd_op_c;
        arg_q <= cmd.cmd_arg;
        rem_q <= is_count(cmd_op_c) ? cmd.cmd_len : LEN_W'(1);
      end else if (step) begin
        rem_q <= rem_q - LEN_W'(1);
      end
    end
  end

  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign busy          = (state_q == S_RUN) || (state_q == S_DONE);
  assign done          = (state_q == S_DONE);
  assign wrap          = wrap_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .ck (ck),
      .rs (rs),
      .t  (t_vec[i]),
      .q  (q[i])
    );
  end

endmodule

// File: tb/tb_tff_seq_ctrl.sv
// Bench for tff_seq_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked each cycle against a behavioural model.
module tb_tff_seq_ctrl;

  localparam int W   = 4;
  localparam int LW  = 8;
  localparam int MAX = (1 << W) - 1;

  logic         ck;
  logic         rs;
  logic         halt;
  logic [W-1:0] t_vec;
  logic [W-1:0] q;
  logic         busy, done, wrap;

  int n_chk  = 0;
  int n_fail = 0;
  bit started = 0;

  tff_seq_ctrl_if #(.WIDTH(W), .LEN_W(LW)) bus ();

  tff_seq_ctrl #(.WIDTH(W), .LEN_W(LW)) dut (
    .ck    (ck),
    .rs    (rs),
    .cmd   (bus),
    .halt  (halt),
    .t_vec (t_vec),
    .q     (q),
    .busy  (busy),
    .done  (done),
    .wrap  (wrap)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Behavioural model: phase 0 idle, 1 stepping, 2 finished.
  int mphase, mq, mrem, mop, marg, mwrap;

  function automatic int next_val(input int op, input int cur, input int arg);
    case (op)
      0:       return 0;
      1:       return arg;
      2:       return (cur + 1) & MAX;
      default: return (cur - 1) & MAX;
    endcase
  endfunction

  function automatic int exp_tvec(input bit h);
    if (mphase == 1 && !h) return mq ^ next_val(mop, mq, marg);
    return 0;
  endfunction

  always @(posedge ck or posedge rs) begin
    if (rs) begin
      mphase = 0; mq = 0; mrem = 0; mop = 0; marg = 0; mwrap = 0;
    end else begin
      int nw;
      nw = 0;
      case (mphase)
        0: if (bus.cmd_valid) begin
          mop  = int'(bus.cmd_op);
          marg = int'(bus.cmd_arg);
          mrem = (mop >= 2) ? int'(bus.cmd_len) : 1;
          mphase = (mop >= 2 && bus.cmd_len == 0) ? 2 : 1;
        end
        1: if (!halt) begin
          int nv;
          nv = next_val(mop, mq, marg);
          nw = ((mop == 2 && mq == MAX && nv == 0) ||
                (mop == 3 && mq == 0 && nv == MAX)) ? 1 : 0;
          mq = nv;
          mrem = mrem - 1;
          if (mrem == 0) mphase = 2;
        end
        default: mphase = 0;
      endcase
      mwrap = nw;
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge ck) begin
    if (started && !rs) begin
      chk("m_ready", int'(bus.cmd_ready), (mphase == 0) ? 1 : 0);
      chk("m_busy",  int'(busy),  (mphase != 0) ? 1 : 0);
      chk("m_done",  int'(done),  (mphase == 2) ? 1 : 0);
      chk("m_tvec",  int'(t_vec), exp_tvec(halt));
      chk("m_q",     int'(q),     mq);
      chk("m_wrap",  int'(wrap),  mwrap);
    end
  end

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 40 && !bus.cmd_ready; k++) tick();
    chk("ready_wait", int'(bus.cmd_ready), 1);
  endtask

  task automatic issue(input int op, input int arg, input int len);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'(op);
    bus.cmd_arg   = W'(arg);
    bus.cmd_len   = LW'(len);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    rs = 1'b1; halt = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_arg = '0; bus.cmd_len = '0;
    #1;
    chk("rst_q", int'(q), 0);
    chk("rst_ready", int'(bus.cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tvec", int'(t_vec), 0);
    chk("rst_wrap", int'(wrap), 0);
    tick();
    rs = 1'b0;
    started = 1;

    // LOAD 1010 from 0000
    issue(1, 4'b1010, 0);
    chk("ld_tvec", int'(t_vec), 4'b1010);
    chk("ld_ready", int'(bus.cmd_ready), 0);
    tick();
    chk("ld_q", int'(q), 4'b1010);
    chk("ld_done", int'(done), 1);
    chk("ld_model_q", mq, 4'b1010);
    tick();
    chk("ld_ready_back", int'(bus.cmd_ready), 1);

    // COUNT_UP len=3 from 1110
    issue(1, 4'b1110, 0); wait_ready();
    issue(2, 0, 3);
    chk("up_tvec0", int'(t_vec), 4'b0001);
    tick(); chk("up_q1", int'(q), 4'b1111); chk("up_w1", int'(wrap), 0);
    tick(); chk("up_q2", int'(q), 4'b0000); chk("up_w2", int'(wrap), 1);
    tick(); chk("up_q3", int'(q), 4'b0001); chk("up_w3", int'(wrap), 0);
    chk("up_done", int'(done), 1);
    tick(); chk("up_idle", int'(bus.cmd_ready), 1); chk("up_done_off", int'(done), 0);

    // COUNT_DOWN len=2 from 0001 with two halted cycles
    issue(1, 4'b0001, 0); wait_ready();
    issue(3, 0, 2);
    chk("dn_tvec0", int'(t_vec), 4'b0001);
    tick(); chk("dn_q1", int'(q), 4'b0000);
    halt = 1'b1; #1 chk("dn_halt_tvec", int'(t_vec), 0);
    tick(); chk("dn_hold1", int'(q), 4'b0000);
    tick(); chk("dn_hold2", int'(q), 4'b0000);
    halt = 1'b0; #1 chk("dn_tvec1", int'(t_vec), 4'b1111);
    tick(); chk("dn_q2", int'(q), 4'b1111); chk("dn_wrap", int'(wrap), 1);
    chk("dn_busy5", int'(busy), 1);
    chk("dn_model_q", mq, 4'b1111);
    tick(); chk("dn_idle", int'(bus.cmd_ready), 1); chk("dn_busy_off", int'(busy), 0);

    // COUNT_UP len=0 from 0101
    issue(1, 4'b0101, 0); wait_ready();
    issue(2, 0, 0);
    chk("z_done", int'(done), 1);
    chk("z_tvec", int'(t_vec), 0);
    chk("z_q", int'(q), 4'b0101);
    tick(); chk("z_ready", int'(bus.cmd_ready), 1); chk("z_q2", int'(q), 4'b0101);

    // Reset in the middle of a long count
    issue(2, 0, 10);
    repeat (4) tick();
    chk("rr_q4", int'(q), 4'b1001);
    #1 rs = 1'b1;
    #1;
    chk("rr_q", int'(q), 0);
    chk("rr_ready", int'(bus.cmd_ready), 1);
    chk("rr_busy", int'(busy), 0);
    chk("rr_tvec", int'(t_vec), 0);
    #1 rs = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd0; bus.cmd_arg = '0; bus.cmd_len = '0;
    tick();
    bus.cmd_valid = 1'b0;
    chk("rr_clr_busy", int'(busy), 1);
    chk("rr_clr_tvec", int'(t_vec), 0);
    tick(); chk("rr_clr_done", int'(done), 1);
    tick();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      bus.cmd_valid = ($urandom_range(0, 2) != 0);
      bus.cmd_op    = 2'($urandom_range(0, 3));
      bus.cmd_arg   = W'($urandom_range(0, MAX));
      bus.cmd_len   = ($urandom_range(0, 9) == 0) ? LW'(17) : LW'($urandom_range(0, 5));
      halt          = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 79) == 0) begin
        #1 rs = 1'b1;
        #1 rs = 1'b0;
      end
      tick();
    end
    bus.cmd_valid = 1'b0;
    halt = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
